// File: rtl/fsm_key_unlock_ctrl.sv
// ---------------------------------------------------------------------------
// fsm_key_unlock_ctrl
//
// Gatekeeper for a protected FSM. The protected FSM stays in reset with its
// clock disabled until the correct multi-word key sequence arrives on key_in.
// After MAX_FAIL wrong attempts in a row, the controller enters a timed
// lockout.
//
// Optional feature: define UNLOCK_TIMEOUT_EN to limit how long the block can
// stay unlocked. When defined, UNLOCKED lasts at most UNLOCK_TMO cycles.
//
// Ports
//   clk        : clock. Every state change happens on the rising edge.
//   rst        : asynchronous reset, active low.
//   start      : begins an unlock attempt. Only sampled in IDLE.
//   key_valid  : key_in holds a valid key word in this cycle.
//   key_in     : key word, KEY_W bits.
//   relock     : forces UNLOCKED back to IDLE.
//   busy       : high while an attempt is being checked (CHECK / FAIL_WAIT).
//   unlocked   : high in UNLOCKED.
//   locked_out : high in LOCKOUT.
//   fsm_en     : clock enable for the protected FSM. High only when unlocked.
//   fsm_rst    : reset for the protected FSM, active high. Low only when
//                unlocked.
//   fail_cnt   : count of consecutive failed attempts. Saturates at MAX_FAIL.
//
// Each flag output is a register decoded from the current state, so a flag
// follows its state by one clock cycle.
// ---------------------------------------------------------------------------
module fsm_key_unlock_ctrl #(
  parameter int unsigned             KEY_W       = 8,
  parameter int unsigned             SEQ_LEN     = 4,
  parameter logic [SEQ_LEN*KEY_W-1:0] KEY_SEQ    = 32'hE10F3CA5,
  parameter int unsigned             MAX_FAIL    = 3,
  parameter int unsigned             LOCKOUT_CYC = 16
`ifdef UNLOCK_TIMEOUT_EN
  , parameter int unsigned           UNLOCK_TMO  = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_in,
  input  logic             relock,
  output logic             busy,
  output logic             unlocked,
  output logic             locked_out,
  output logic             fsm_en,
  output logic             fsm_rst,
  output logic [2:0]       fail_cnt
);

  localparam int unsigned IDX_W  = $clog2(SEQ_LEN);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYC + 1);
`ifdef UNLOCK_TIMEOUT_EN
  localparam int unsigned TMO_W  = $clog2(UNLOCK_TMO + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_FAIL_WAIT = 3'd2,
    S_UNLOCKED  = 3'd3,
    S_LOCKOUT   = 3'd4
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               mismatch_reg;
  logic [LOCK_W-1:0]  lock_timer_reg;
`ifdef UNLOCK_TIMEOUT_EN
  logic [TMO_W-1:0]   tmo_timer_reg;
`endif

  // Split the packed key into words. Word 0 is checked first.
  logic [KEY_W-1:0] key_word [SEQ_LEN];
  for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_key_word
    assign key_word[gi] = KEY_SEQ[gi*KEY_W +: KEY_W];
  end

  logic word_bad;
  logic last_word;
  assign word_bad  = (key_in != key_word[idx_reg]);
  assign last_word = (idx_reg == IDX_W'(SEQ_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      idx_reg        <= '0;
      mismatch_reg   <= 1'b0;
      lock_timer_reg <= '0;
`ifdef UNLOCK_TIMEOUT_EN
      tmo_timer_reg  <= '0;
`endif
      fail_cnt       <= 3'd0;
      busy           <= 1'b0;
      unlocked       <= 1'b0;
      locked_out     <= 1'b0;
      fsm_en         <= 1'b0;
      fsm_rst        <= 1'b1;
    end else begin
      busy       <= (state_reg == S_CHECK) || (state_reg == S_FAIL_WAIT);
      unlocked   <= (state_reg == S_UNLOCKED);
      fsm_en     <= (state_reg == S_UNLOCKED);
      fsm_rst    <= (state_reg != S_UNLOCKED);
      locked_out <= (state_reg == S_LOCKOUT);

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg    <= S_CHECK;
            idx_reg      <= '0;
            mismatch_reg <= 1'b0;
          end
        end

        S_CHECK: begin
          // Every word is consumed, even after a mismatch. This keeps the
          // attempt length independent of where the first wrong word was.
          if (key_valid) begin
            if (last_word) begin
              idx_reg      <= '0;
              mismatch_reg <= 1'b0;
              if (mismatch_reg || word_bad) begin
                state_reg <= S_FAIL_WAIT;
                if (fail_cnt < 3'(MAX_FAIL)) begin
                  fail_cnt <= fail_cnt + 3'd1;
                end
              end else begin
                state_reg <= S_UNLOCKED;
                fail_cnt  <= 3'd0;
`ifdef UNLOCK_TIMEOUT_EN
                tmo_timer_reg <= TMO_W'(UNLOCK_TMO);
`endif
              end
            end else begin
              idx_reg      <= idx_reg + 1'b1;
              mismatch_reg <= mismatch_reg | word_bad;
            end
          end
        end

        S_FAIL_WAIT: begin
          if (fail_cnt == 3'(MAX_FAIL)) begin
            state_reg      <= S_LOCKOUT;
            lock_timer_reg <= LOCK_W'(LOCKOUT_CYC);
          end else begin
            state_reg <= S_IDLE;
          end
        end

        S_UNLOCKED: begin
`ifdef UNLOCK_TIMEOUT_EN
          if (relock || (tmo_timer_reg == TMO_W'(1))) begin
            state_reg     <= S_IDLE;
            tmo_timer_reg <= '0;
          end else begin
            tmo_timer_reg <= tmo_timer_reg - 1'b1;
          end
`else
          if (relock) begin
            state_reg <= S_IDLE;
          end
`endif
        end

        S_LOCKOUT: begin
          // The timer is loaded with LOCKOUT_CYC. Leaving at a count of 1
          // gives exactly LOCKOUT_CYC cycles in this state.
          if (lock_timer_reg == LOCK_W'(1)) begin
            state_reg      <= S_IDLE;
            lock_timer_reg <= '0;
            fail_cnt       <= 3'd0;
          end else begin
            lock_timer_reg <= lock_timer_reg - 1'b1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_key_unlock_ctrl.sv
module tb_fsm_key_unlock_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       key_valid;
  logic [7:0] key_in;
  logic       relock;
  logic       busy;
  logic       unlocked;
  logic       locked_out;
  logic       fsm_en;
  logic       fsm_rst;
  logic [2:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  // Packed as {w3,w2,w1,w0}; word 0 is sent first.
  localparam logic [31:0] GOOD_SEQ = 32'hE10F3CA5;
  localparam logic [31:0] BAD_SEQ  = 32'hE10F00A5;

  fsm_key_unlock_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .relock     (relock),
    .busy       (busy),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fsm_en     (fsm_en),
    .fsm_rst    (fsm_rst),
    .fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle, then sends four words. When gap is nonzero,
  // each of the first three words is followed by that many idle cycles, and
  // busy is checked in each idle cycle.
  task automatic attempt(input logic [31:0] seq, input int gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_in    = seq[i*8 +: 8];
      tick();
      key_valid = 1'b0;
      key_in    = 8'h00;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check("busy_in_gap", {31'd0, busy}, 32'd1);
        end
      end
    end
  endtask

  // Counts how many sampled cycles a flag is high. Counting stops when the
  // flag falls after having been high. When poke is set, start is driven
  // high during samples 1..4 to show that it is ignored.
  task automatic measure_pulse(input int sel, input bit poke, output int n);
    bit seen;
    logic v;
    n    = 0;
    seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      v = (sel == 0) ? unlocked : locked_out;
      if (v) begin
        n++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      start = poke && (t >= 1) && (t < 5);
      tick();
    end
    start = 1'b0;
  endtask

  int n;

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    key_valid = 1'b0;
    key_in    = 8'h00;
    relock    = 1'b0;
    #23;
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_unlocked",   {31'd0, unlocked},   32'd0);
    check("rst_locked_out", {31'd0, locked_out}, 32'd0);
    check("rst_fsm_en",     {31'd0, fsm_en},     32'd0);
    check("rst_fsm_rst",    {31'd0, fsm_rst},    32'd1);
    check("rst_fail_cnt",   {29'd0, fail_cnt},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: correct sequence on back-to-back cycles
    attempt(GOOD_SEQ, 0);
    tick();
    check("t1_unlocked", {31'd0, unlocked}, 32'd1);
    check("t1_fsm_en",   {31'd0, fsm_en},   32'd1);
    check("t1_fsm_rst",  {31'd0, fsm_rst},  32'd0);
    check("t1_fail_cnt", {29'd0, fail_cnt}, 32'd0);
    check("t1_busy",     {31'd0, busy},     32'd0);

    // start and key words are ignored while unlocked
    start     = 1'b1;
    key_valid = 1'b1;
    key_in    = 8'h55;
    repeat (3) tick();
    start     = 1'b0;
    key_valid = 1'b0;
    tick();
    check("unl_ignore_unlocked", {31'd0, unlocked}, 32'd1);
    check("unl_ignore_busy",     {31'd0, busy},     32'd0);

`ifndef UNLOCK_TIMEOUT_EN
    repeat (100) tick();
    check("unl_persist", {31'd0, unlocked}, 32'd1);
`endif

    // 5a: relock
    relock = 1'b1;
    tick();
    relock = 1'b0;
    tick();
    check("relock_unlocked", {31'd0, unlocked}, 32'd0);
    check("relock_fsm_rst",  {31'd0, fsm_rst},  32'd1);
    check("relock_fsm_en",   {31'd0, fsm_en},   32'd0);

    // 2: correct sequence with 3 idle cycles between words
    attempt(GOOD_SEQ, 3);
    tick();
    check("t2_unlocked", {31'd0, unlocked}, 32'd1);
    // start together with relock: relock wins
    relock = 1'b1;
    start  = 1'b1;
    tick();
    relock = 1'b0;
    start  = 1'b0;
    tick();
    check("t2_relock_unlocked", {31'd0, unlocked}, 32'd0);
    check("t2_relock_busy",     {31'd0, busy},     32'd0);

    // 3: one wrong word, all four still consumed
    attempt(BAD_SEQ, 0);
    repeat (2) tick();
    check("t3_fail_cnt",   {29'd0, fail_cnt},   32'd1);
    check("t3_unlocked",   {31'd0, unlocked},   32'd0);
    check("t3_busy",       {31'd0, busy},       32'd0);
    check("t3_locked_out", {31'd0, locked_out}, 32'd0);

    // 4: two more failures lead to a lockout
    attempt(BAD_SEQ, 0);
    repeat (2) tick();
    check("t4_fail_cnt2", {29'd0, fail_cnt}, 32'd2);
    attempt(BAD_SEQ, 0);
    check("t4_fail_cnt3", {29'd0, fail_cnt}, 32'd3);
    measure_pulse(1, 1'b1, n);
    check("t4_lockout_len", n, 32'd16);
    check("t4_fail_cnt0",   {29'd0, fail_cnt}, 32'd0);
    tick();
    check("t4_busy_after",  {31'd0, busy},     32'd0);
    attempt(GOOD_SEQ, 0);
    tick();
    check("t4_unlock_after", {31'd0, unlocked}, 32'd1);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    repeat (2) tick();

    // 5b: reset in the middle of an attempt, after one earlier failure
    attempt(BAD_SEQ, 0);
    repeat (2) tick();
    check("t5_fail_pre", {29'd0, fail_cnt}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      key_valid = 1'b1;
      key_in    = GOOD_SEQ[i*8 +: 8];
      tick();
    end
    key_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("t5_rst_busy",     {31'd0, busy},     32'd0);
    check("t5_rst_fail_cnt", {29'd0, fail_cnt}, 32'd0);
    check("t5_rst_fsm_rst",  {31'd0, fsm_rst},  32'd1);
    @(negedge clk);
    rst = 1'b1;
    // the last two words alone, without start, must not unlock
    for (int i = 2; i < 4; i++) begin
      key_valid = 1'b1;
      key_in    = GOOD_SEQ[i*8 +: 8];
      tick();
    end
    key_valid = 1'b0;
    repeat (2) tick();
    check("t5_no_partial", {31'd0, unlocked}, 32'd0);

`ifdef UNLOCK_TIMEOUT_EN
    // 6: UNLOCKED times out after UNLOCK_TMO cycles
    attempt(GOOD_SEQ, 0);
    measure_pulse(0, 1'b0, n);
    check("t6_unlock_len", n, 32'd64);
    check("t6_fsm_rst",    {31'd0, fsm_rst}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
